sqrt_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit integer square-root engine (odd-subtraction type, St/Done handshake) among NREQ requesters. It latches the granted operand, issues a one-cycle start to the engine, and waits for completion or timeout. It then returns the 4-bit root to the granted requester with a one-cycle acknowledge. It sits between the client blocks and the single engine instance.

---
 rtl/sqrt_req_arbiter_pkg.sv | 14 +
 rtl/sqrt_req_arbiter_rr_pick.sv | 26 ++
 rtl/sqrt_req_arbiter.sv | 120 ++++++++++++
 tb/tb_sqrt_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_req_arbiter_pkg.sv
// rtl/sqrt_req_arbiter_pkg.sv - shared state encoding and operand/result widths for the sqrt arbiter
package sqrt_req_arbiter_pkg;

  localparam int OPW  = 8;
  localparam int RESW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_req_arbiter_rr_pick.sv
// rtl/sqrt_req_arbiter_rr_pick.sv - combinational rotating-priority pick starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);

  // Scan offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int p = 0; p < NREQ; p++) begin
        if (ptr == IDW'(p) && req[(p + k) % NREQ]) begin
          gnt_valid = 1'b1;
          gnt_idx   = IDW'((p + k) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// rtl/sqrt_req_arbiter.sv - round-robin sequencer sharing one sqrt engine among NREQ clients
module sqrt_req_arbiter
  import sqrt_req_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = 3
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_n,
  output logic [NREQ-1:0]   ack,
  output logic [RESW-1:0]   result,
  output logic              err,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              eng_st,
  output logic [OPW-1:0]    eng_n,
  input  logic              eng_done,
  input  logic [RESW-1:0]   eng_sqrt
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;
  logic [OPW-1:0]  sel_n;
  logic [NREQ-1:0] ack_vec;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // Operand of the requester the picker would grant this cycle.
  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) sel_n = req_n[i*OPW +: OPW];
    end
  end

  // One-hot acknowledge vector for the currently granted requester.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_vec[i] = (grant_id == IDW'(i));
    end
  end

  // Sequencer: grant, start the engine, wait for done or timeout, then acknowledge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      ack      <= '0;
      result   <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      eng_st   <= 1'b0;
      eng_n    <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      ack    <= '0;
      eng_st <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            grant_id <= gnt_idx;
            eng_n    <= sel_n;
            eng_st   <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last counted cycle still counts as success.
          if (eng_done) begin
            result <= eng_sqrt;
            err    <= 1'b0;
            state  <= RESP;
          end else if (cnt == CNT_LAST) begin
            result <= '0;
            err    <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ack   <= ack_vec;
          ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// tb/tb_sqrt_req_arbiter.sv - scoreboard bench for sqrt_req_arbiter with a behavioural engine
module tb_sqrt_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 3;

  logic              clk = 1'b0;
  logic              resetN;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_n;
  logic [NREQ-1:0]   ack;
  logic [3:0]        result;
  logic              err;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              eng_st;
  logic [7:0]        eng_n;
  logic              eng_done;
  logic [3:0]        eng_sqrt;

  always #5 clk = ~clk;

  sqrt_req_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT),
    .IDW    (IDW)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .req     (req),
    .req_n   (req_n),
    .ack     (ack),
    .result  (result),
    .err     (err),
    .busy    (busy),
    .grant_id(grant_id),
    .eng_st  (eng_st),
    .eng_n   (eng_n),
    .eng_done(eng_done),
    .eng_sqrt(eng_sqrt)
  );

  typedef struct {
    int idx;
    int res;
    int err;
  } exp_t;

  exp_t sb[$];
  int   exp_n[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acks   = 0;
  int eng_delay = 0;
  int eng_cnt   = 0;
  int st_cyc    = 0;
  int done_cyc  = 0;
  bit eng_active = 1'b0;
  bit prev_st    = 1'b0;
  bit stray      = 1'b0;
  logic [7:0]      eng_op = '0;
  logic [NREQ-1:0] keep   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int isqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  task automatic expect_serve(input int idx, input int op, input bit to);
    exp_t e;
    e.idx = idx;
    e.res = to ? 0 : isqrt(op);
    e.err = to ? 1 : 0;
    sb.push_back(e);
    exp_n.push_back(op);
  endtask

  task automatic raise(input int idx, input int op);
    req_n[idx*8 +: 8] = 8'(op);
    req[idx] = 1'b1;
  endtask

  // One negedge: scoreboard monitor, requester drop-on-ack, engine model.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (ack != '0) begin
      n_acks++;
      check("ack_onehot", 32'($onehot(ack)), 1);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 0);
      end else begin
        e = sb.pop_front();
        check("ack_vec", 32'(ack), 32'(1) << e.idx);
        check("grant_id", 32'(grant_id), e.idx);
        check("result", 32'(result), e.res);
        check("err", 32'(err), e.err);
        if (e.err != 0) check("timeout_latency", cyc - st_cyc, TIMEOUT + 2);
        else            check("done_latency", cyc - done_cyc, 2);
      end
      req = req & ~(ack & ~keep);
    end
    eng_done = 1'b0;
    if (stray) begin
      eng_done = 1'b1;
      eng_sqrt = 4'hf;
      stray = 1'b0;
    end
    if (eng_active) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        eng_sqrt   = 4'(isqrt(int'(eng_op)));
        eng_active = 1'b0;
        done_cyc   = cyc;
      end
    end
    if (eng_st) begin
      check("st_single_cycle", 32'(prev_st), 0);
      if (exp_n.size() == 0) check("unexpected_st", 32'(eng_n), 32'hffff_ffff);
      else check("eng_n", 32'(eng_n), exp_n.pop_front());
      eng_op = eng_n;
      st_cyc = cyc;
      if (eng_delay > 0 && !prev_st) begin
        eng_active = 1'b1;
        eng_cnt    = eng_delay;
      end
    end
    prev_st = eng_st;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    step();
    while ((sb.size() != 0 || busy || req != '0) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_eng_st"}, 32'(eng_st), 0);
    check({tag, "_eng_n"}, 32'(eng_n), 0);
  endtask

  initial begin
    int base;
    int n;
    resetN   = 1'b0;
    req      = '0;
    req_n    = '0;
    eng_done = 1'b0;
    eng_sqrt = '0;
    repeat (3) step();
    check_reset_outputs("reset");
    resetN = 1'b1;
    step();

    // All four at once from ptr=0: served 0,1,2,3.
    eng_delay = 4;
    raise(0, 0);   raise(1, 1);   raise(2, 144); raise(3, 255);
    expect_serve(0, 0, 0); expect_serve(1, 1, 0);
    expect_serve(2, 144, 0); expect_serve(3, 255, 0);
    base = n_acks;
    drain(400);
    check("simul_ack_count", n_acks - base, 4);

    // Single request, engine answers 20 cycles after start.
    eng_delay = 20;
    raise(2, 49);
    expect_serve(2, 49, 0);
    drain(200);
    check("single_busy_after", 32'(busy), 0);

    // Fairness: req[0] and req[3] held; ptr=3 so 3,0,3,0,3,0.
    eng_delay = 3;
    keep = 4'b1001;
    raise(0, 36); raise(3, 225);
    for (int i = 0; i < 3; i++) begin
      expect_serve(3, 225, 0);
      expect_serve(0, 36, 0);
    end
    base = n_acks;
    n = 0;
    while (n_acks < base + 5 && n < 500) begin
      step();
      n++;
    end
    check("fair_progress", 32'(n < 500), 1);
    req[3] = 1'b0;
    keep   = '0;
    drain(200);

    // Timeout: engine silent, then the next request is served normally.
    eng_delay = 0;
    raise(1, 100);
    expect_serve(1, 100, 1);
    drain(300);
    eng_delay = 5;
    raise(2, 200);
    expect_serve(2, 200, 0);
    drain(200);

    // Done on the last counted WAIT cycle wins; one cycle later is a timeout.
    eng_delay = TIMEOUT;
    raise(0, 81);
    expect_serve(0, 81, 0);
    drain(300);
    eng_delay = TIMEOUT + 1;
    raise(1, 16);
    expect_serve(1, 16, 1);
    drain(300);

    // A stray done while idle must not acknowledge anything.
    base = n_acks;
    stray = 1'b1;
    repeat (6) step();
    check("stray_no_ack", n_acks - base, 0);
    check("stray_idle", 32'(busy), 0);

    // Reset in WAIT: no ack, and ptr restarts at 0 (ptr was 2 before).
    eng_delay = 0;
    raise(2, 50);
    exp_n.push_back(50);
    repeat (10) step();
    check("pre_reset_busy", 32'(busy), 1);
    resetN = 1'b0;
    req    = '0;
    eng_active = 1'b0;
    repeat (2) step();
    check_reset_outputs("midreset");
    resetN = 1'b1;
    step();
    check_reset_outputs("postreset");
    eng_delay = 3;
    raise(1, 4); raise(3, 9);
    expect_serve(1, 4, 0);
    expect_serve(3, 9, 0);
    drain(200);

    check("scoreboard_empty", sb.size(), 0);
    check("operand_queue_empty", exp_n.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
